// File: rtl/synth_dac_pkg.sv
// -----------------------------------------------------------------------------
// synth_dac_pkg
// Shared types and constants for the DAC output path (dac_spi_tx and its
// sub-modules): FSM state encoding, MCP4921-style frame layout constants,
// the dither LFSR seed and small helper functions.
// -----------------------------------------------------------------------------
package synth_dac_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SHIFT   = 3'd2,
        CS_HOLD = 3'd3,
        LDAC    = 3'd4
    } state_e;

    localparam int          FRAME_BITS   = 16;
    // DAC A, unbuffered Vref, 1x gain, output active.
    localparam logic [3:0]  DAC_CFG_BITS = 4'b0011;
    localparam logic [11:0] MIDSCALE     = 12'h800;
    localparam logic [14:0] LFSR_SEED    = 15'h0001;

    // Build the 16-bit command word from a 12-bit DAC code.
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [11:0] code);
        return {DAC_CFG_BITS, code};
    endfunction

    // One step of the x^15 + x^14 + 1 Fibonacci LFSR.
    function automatic logic [14:0] lfsr_next(input logic [14:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction

endpackage

// File: rtl/dac_spi_tx_chk.sv
// -----------------------------------------------------------------------------
// dac_spi_tx_chk
// Simulation checker for dac_spi_tx: a sample tick must only arrive while the
// frame FSM is idle. The frame is never restarted, so a tick elsewhere means
// SAMPLE_PERIOD is too short for the configured CLK_DIV.
// Ports:
//   clk, rst - clock and synchronous reset of the checked block
//   tick     - sample tick
//   in_idle  - FSM is in IDLE
// -----------------------------------------------------------------------------
module dac_spi_tx_chk (
    input logic clk,
    input logic rst,
    input logic tick,
    input logic in_idle
);

    a_tick_in_idle: assert property (@(posedge clk) disable iff (rst) tick |-> in_idle)
        else $error("dac_spi_tx: sample tick while a frame is in progress");

endmodule

// File: rtl/dac_spi_tx_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Modulo-PERIOD free-running counter producing a one-cycle tick when the
// count reaches PERIOD-1. Synchronous active-high reset clears the count.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset (count -> 0)
//   tick_o - high for one cycle every PERIOD cycles
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int PERIOD = 250
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int         W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: wrap to zero after the last value.
    always_comb begin
        count_d = count_q;
        if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = (count_q == LAST);

endmodule

// File: rtl/dac_spi_tx.sv
// -----------------------------------------------------------------------------
// dac_spi_tx
// Output end of the synth sample path. Buffers one 11-bit sample behind a
// valid/ready handshake and, on every sample tick, shifts a 16-bit
// MCP4921-style command frame (MSB first, SPI mode 0) followed by an LDAC
// pulse so the analog output updates on a fixed sample grid.
// Optional feature: define DAC_LFSR_DITHER_EN to drive the code LSB from a
// 15-bit LFSR (advanced once per tick); otherwise the LSB is always 0.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   sample        - unsigned 11-bit channel sample
//   sample_valid  - sample is valid this cycle
//   sample_ready  - one-entry buffer is empty
//   dac_csn       - SPI chip select, active low
//   dac_sclk      - SPI clock, idles low
//   dac_mosi      - SPI data, MSB first
//   dac_ldacn     - DAC latch strobe, active low
//   underrun      - one-cycle pulse: tick found the buffer empty
// -----------------------------------------------------------------------------
module dac_spi_tx
    import synth_dac_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] sample,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        dac_csn,
    output logic        dac_sclk,
    output logic        dac_mosi,
    output logic        dac_ldacn,
    output logic        underrun
);

    generate
        if (CLK_DIV < 1) begin : g_bad_clk_div
            $error("dac_spi_tx: CLK_DIV must be >= 1");
        end
        if (SAMPLE_PERIOD < 36 * CLK_DIV) begin : g_bad_sample_period
            $error("dac_spi_tx: SAMPLE_PERIOD must be >= 36*CLK_DIV");
        end
    endgenerate

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    state_e                  state_q, state_d;
    logic                    tick_s, half_tick_s, div_rst_s, code_lsb_s;
    logic                    load_s, consume_s;
    logic                    buf_full_q, buf_full_d;
    logic [10:0]             buf_data_q, buf_data_d;
    logic                    ready_q, ready_d;
    logic [11:0]             last_code_q, last_code_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d, frame_s;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic                    csn_q, csn_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic                    ldacn_q, ldacn_d, underrun_q, underrun_d;

    tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_sample_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick_s)
    );

    // Half-period divider is held in reset while idle so every frame starts
    // with a fresh CLK_DIV-cycle phase.
    assign div_rst_s = rst || (state_q == IDLE);

    tick_gen #(.PERIOD(CLK_DIV)) u_half_tick (
        .clk    (clk),
        .rst    (div_rst_s),
        .tick_o (half_tick_s)
    );

`ifdef DAC_LFSR_DITHER_EN
    logic [14:0] lfsr_q, lfsr_d;

    // Dither LFSR advances once per sample tick.
    always_comb begin
        lfsr_d = lfsr_q;
        if (tick_s) begin
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Dither LFSR register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign code_lsb_s = lfsr_q[0];
`else
    assign code_lsb_s = 1'b0;
`endif

    // ready mirrors "buffer empty", so load and consume never coincide.
    assign load_s    = sample_valid && ready_q;
    assign consume_s = tick_s && buf_full_q;

    // Buffer, code and underrun next-state.
    always_comb begin
        buf_full_d  = buf_full_q;
        buf_data_d  = buf_data_q;
        last_code_d = last_code_q;
        if (load_s) begin
            buf_full_d = 1'b1;
            buf_data_d = sample;
        end else if (consume_s) begin
            buf_full_d = 1'b0;
        end else begin
            buf_full_d = buf_full_q;
        end
        // A repeat keeps the previous code but still takes a fresh LSB.
        if (consume_s) begin
            last_code_d = {buf_data_q, code_lsb_s};
        end else if (tick_s) begin
            last_code_d = {last_code_q[11:1], code_lsb_s};
        end else begin
            last_code_d = last_code_q;
        end
        ready_d    = ~buf_full_d;
        underrun_d = tick_s && !buf_full_q;
    end

    assign frame_s = frame_word(last_code_d);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            buf_full_q  <= 1'b0;
            buf_data_q  <= 11'd0;
            ready_q     <= 1'b1;
            last_code_q <= MIDSCALE;
            shift_q     <= '0;
            bit_cnt_q   <= 4'd0;
            csn_q       <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            ldacn_q     <= 1'b1;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_full_q  <= buf_full_d;
            buf_data_q  <= buf_data_d;
            ready_q     <= ready_d;
            last_code_q <= last_code_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            csn_q       <= csn_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            ldacn_q     <= ldacn_d;
            underrun_q  <= underrun_d;
        end
    end

    // Frame FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick_s) state_d = SETUP; else state_d = IDLE;
            SETUP:   if (half_tick_s) state_d = SHIFT; else state_d = SETUP;
            SHIFT:   if (half_tick_s && sclk_q && (bit_cnt_q == LAST_BIT)) state_d = CS_HOLD;
                     else state_d = SHIFT;
            CS_HOLD: if (half_tick_s) state_d = LDAC; else state_d = CS_HOLD;
            LDAC:    if (half_tick_s) state_d = IDLE; else state_d = LDAC;
            default: state_d = IDLE;
        endcase
    end

    // Frame FSM outputs. Each SCLK period starts with its low half, so the
    // first rising edge comes 2*CLK_DIV cycles after chip select falls.
    always_comb begin
        csn_d     = csn_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ldacn_d   = ldacn_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (tick_s) begin
                    shift_d   = frame_s;
                    mosi_d    = frame_s[FRAME_BITS-1];
                    csn_d     = 1'b0;
                    sclk_d    = 1'b0;
                    bit_cnt_d = 4'd0;
                end else begin
                    csn_d = 1'b1;
                end
            end
            SETUP: sclk_d = 1'b0;
            SHIFT: begin
                if (half_tick_s) begin
                    sclk_d = ~sclk_q;
                    // Falling edge: advance data, or end the frame after bit 0.
                    if (sclk_q && (bit_cnt_q == LAST_BIT)) begin
                        csn_d = 1'b1;
                    end else if (sclk_q) begin
                        shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
                        mosi_d    = shift_q[FRAME_BITS-2];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end else begin
                    sclk_d = sclk_q;
                end
            end
            CS_HOLD: if (half_tick_s) ldacn_d = 1'b0; else ldacn_d = ldacn_q;
            LDAC:    if (half_tick_s) ldacn_d = 1'b1; else ldacn_d = ldacn_q;
            default: begin
                csn_d   = 1'b1;
                sclk_d  = 1'b0;
                ldacn_d = 1'b1;
            end
        endcase
    end

    dac_spi_tx_chk u_chk (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick_s),
        .in_idle (state_q == IDLE)
    );

    assign sample_ready = ready_q;
    assign dac_csn      = csn_q;
    assign dac_sclk     = sclk_q;
    assign dac_mosi     = mosi_q;
    assign dac_ldacn    = ldacn_q;
    assign underrun     = underrun_q;

endmodule
